// File: rtl/cpu_pkg.sv
// cpu_pkg: ALU opcode encodings, CCR bit positions and a flag-class helper
// shared by the execute stage and its ALU.
package cpu_pkg;

  localparam logic [5:0] ALU_NOP  = 6'd0;
  localparam logic [5:0] ALU_MOV  = 6'd1;
  localparam logic [5:0] ALU_ADD  = 6'd2;
  localparam logic [5:0] ALU_SUB  = 6'd3;
  localparam logic [5:0] ALU_AND  = 6'd4;
  localparam logic [5:0] ALU_OR   = 6'd5;
  localparam logic [5:0] ALU_NOT  = 6'd6;
  localparam logic [5:0] ALU_INC  = 6'd7;
  localparam logic [5:0] ALU_DEC  = 6'd8;
  localparam logic [5:0] ALU_SETC = 6'd9;
  localparam logic [5:0] ALU_CLRC = 6'd10;
  localparam logic [5:0] ALU_RLC  = 6'd11;
  localparam logic [5:0] ALU_RRC  = 6'd12;

  // CCR layout {V,C,N,Z}
  localparam int CCR_Z = 0;
  localparam int CCR_N = 1;
  localparam int CCR_C = 2;
  localparam int CCR_V = 3;

  // Ops whose result drives Z and N
  function automatic logic op_sets_zn(input logic [5:0] op);
    return ((op >= ALU_ADD) && (op <= ALU_DEC)) || (op == ALU_RLC) || (op == ALU_RRC);
  endfunction

endpackage

// File: rtl/alu_core.sv
// alu_core: purely combinational ALU. Produces the result and the next CCR
// from the current CCR; flags not touched by an op pass through unchanged.
module alu_core
  import cpu_pkg::*;
#(
  parameter int DATA_W = 8
) (
  input  logic [5:0]        op_i,
  input  logic [DATA_W-1:0] a_i,
  input  logic [DATA_W-1:0] b_i,
  input  logic [3:0]        ccr_i,
  output logic [DATA_W-1:0] result_o,
  output logic [3:0]        ccr_o
);

  localparam int M = DATA_W - 1;
  localparam logic [DATA_W:0] ONE = {{DATA_W{1'b0}}, 1'b1};

  logic [DATA_W:0] sum;

  // Result and flag generation; top bit of the extended sum is carry/borrow
  always_comb begin
    result_o = '0;
    ccr_o    = ccr_i;
    sum      = '0;
    case (op_i)
      ALU_MOV: result_o = b_i;
      ALU_ADD: begin
        sum          = {1'b0, a_i} + {1'b0, b_i};
        result_o     = sum[M:0];
        ccr_o[CCR_C] = sum[DATA_W];
        ccr_o[CCR_V] = (a_i[M] == b_i[M]) && (result_o[M] != a_i[M]);
      end
      ALU_SUB: begin
        sum          = {1'b0, a_i} - {1'b0, b_i};
        result_o     = sum[M:0];
        ccr_o[CCR_C] = sum[DATA_W];
        ccr_o[CCR_V] = (a_i[M] != b_i[M]) && (result_o[M] != a_i[M]);
      end
      ALU_AND: result_o = a_i & b_i;
      ALU_OR:  result_o = a_i | b_i;
      ALU_NOT: result_o = ~a_i;
      ALU_INC: begin
        sum          = {1'b0, a_i} + ONE;
        result_o     = sum[M:0];
        ccr_o[CCR_C] = sum[DATA_W];
        ccr_o[CCR_V] = !a_i[M] && result_o[M];
      end
      ALU_DEC: begin
        sum          = {1'b0, a_i} - ONE;
        result_o     = sum[M:0];
        ccr_o[CCR_C] = sum[DATA_W];
        ccr_o[CCR_V] = a_i[M] && !result_o[M];
      end
      ALU_SETC: ccr_o[CCR_C] = 1'b1;
      ALU_CLRC: ccr_o[CCR_C] = 1'b0;
      ALU_RLC: begin
        result_o     = {a_i[M-1:0], ccr_i[CCR_C]};
        ccr_o[CCR_C] = a_i[M];
      end
      ALU_RRC: begin
        result_o     = {ccr_i[CCR_C], a_i[M:1]};
        ccr_o[CCR_C] = a_i[0];
      end
      default: ;
    endcase
    if (op_sets_zn(op_i)) begin
      ccr_o[CCR_Z] = (result_o == '0);
      ccr_o[CCR_N] = result_o[M];
    end
  end

endmodule

// File: rtl/ex_mem_stage.sv
// ex_mem_stage: execute stage and EX/MEM register with CCR and optional
// interrupt shadow copy. Optional feature macro: CCR_SHADOW_EN (shadow CCR
// with save/restore); without it the shadow reads as zero.
module ex_mem_stage
  import cpu_pkg::*;
#(
  parameter int DATA_W = 8,
  parameter int ADDR_W = 8
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              stall_M,
  input  logic              flush_M,
  input  logic [5:0]        alu_control_E,
  input  logic [DATA_W-1:0] src_a_E,
  input  logic [DATA_W-1:0] src_b_E,
  input  logic              wr_en_regf_E,
  input  logic              wr_en_dmem_E,
  input  logic              rd_en_E,
  input  logic              f_save_E,
  input  logic              f_restore_E,
  input  logic [1:0]        rd_addr_E,
  input  logic [ADDR_W-1:0] mem_addr_E,
  output logic [DATA_W-1:0] alu_result_M,
  output logic [DATA_W-1:0] store_data_M,
  output logic [ADDR_W-1:0] mem_addr_M,
  output logic [1:0]        rd_addr_M,
  output logic              wr_en_regf_M,
  output logic              wr_en_dmem_M,
  output logic              rd_en_M,
  output logic [3:0]        ccr_o,
  output logic [3:0]        ccr_shadow_o
);

  logic [DATA_W-1:0] alu_res;
  logic [3:0]        alu_ccr;
  logic [DATA_W-1:0] alu_result_q, store_data_q;
  logic [ADDR_W-1:0] mem_addr_q;
  logic [1:0]        rd_addr_q;
  logic              wr_en_regf_q, wr_en_dmem_q, rd_en_q;
  logic [3:0]        ccr_q, ccr_d;

  // Side effects only for an instruction that actually enters M
  logic commit;
  assign commit = !flush_M && !stall_M;

  alu_core #(.DATA_W(DATA_W)) u_alu (
    .op_i     (alu_control_E),
    .a_i      (src_a_E),
    .b_i      (src_b_E),
    .ccr_i    (ccr_q),
    .result_o (alu_res),
    .ccr_o    (alu_ccr)
  );

  // EX/MEM register: flush inserts a NOP and wins over stall
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      alu_result_q <= '0;
      store_data_q <= '0;
      mem_addr_q   <= '0;
      rd_addr_q    <= '0;
      wr_en_regf_q <= 1'b0;
      wr_en_dmem_q <= 1'b0;
      rd_en_q      <= 1'b0;
    end else if (flush_M) begin
      alu_result_q <= '0;
      store_data_q <= '0;
      mem_addr_q   <= '0;
      rd_addr_q    <= '0;
      wr_en_regf_q <= 1'b0;
      wr_en_dmem_q <= 1'b0;
      rd_en_q      <= 1'b0;
    end else if (!stall_M) begin
      alu_result_q <= alu_res;
      store_data_q <= src_b_E;
      mem_addr_q   <= mem_addr_E;
      rd_addr_q    <= rd_addr_E;
      wr_en_regf_q <= wr_en_regf_E;
      wr_en_dmem_q <= wr_en_dmem_E;
      rd_en_q      <= rd_en_E;
    end
  end

`ifdef CCR_SHADOW_EN
  logic [3:0] shadow_q, shadow_d;

  // Restore overrides the ALU flags; save captures the pre-instruction CCR,
  // so save+restore together swaps the two registers
  always_comb begin
    ccr_d    = f_restore_E ? shadow_q : alu_ccr;
    shadow_d = f_save_E ? ccr_q : shadow_q;
  end

  // Shadow register updates only on a committed instruction
  always_ff @(posedge clk or negedge reset) begin
    if (!reset)      shadow_q <= '0;
    else if (commit) shadow_q <= shadow_d;
  end

  assign ccr_shadow_o = shadow_q;
`else
  logic unused_shadow_ctl;
  assign unused_shadow_ctl = f_save_E ^ f_restore_E;

  // Without a shadow the CCR simply follows the ALU
  always_comb begin
    ccr_d = alu_ccr;
  end

  assign ccr_shadow_o = 4'b0;
`endif

  // CCR register: squashed or stalled instructions leave it untouched
  always_ff @(posedge clk or negedge reset) begin
    if (!reset)      ccr_q <= '0;
    else if (commit) ccr_q <= ccr_d;
  end

  assign alu_result_M = alu_result_q;
  assign store_data_M = store_data_q;
  assign mem_addr_M   = mem_addr_q;
  assign rd_addr_M    = rd_addr_q;
  assign wr_en_regf_M = wr_en_regf_q;
  assign wr_en_dmem_M = wr_en_dmem_q;
  assign rd_en_M      = rd_en_q;
  assign ccr_o        = ccr_q;

endmodule

// File: tb/tb_ex_mem_stage.sv
// tb_ex_mem_stage: randomized and directed checks of ex_mem_stage against an
// arithmetic reference model. Honours CCR_SHADOW_EN like the design.
module tb_ex_mem_stage;

  logic       clk = 1'b0;
  logic       reset;
  logic       stall_M, flush_M;
  logic [5:0] alu_control_E;
  logic [7:0] src_a_E, src_b_E, mem_addr_E;
  logic       wr_en_regf_E, wr_en_dmem_E, rd_en_E, f_save_E, f_restore_E;
  logic [1:0] rd_addr_E;
  logic [7:0] alu_result_M, store_data_M, mem_addr_M;
  logic [1:0] rd_addr_M;
  logic       wr_en_regf_M, wr_en_dmem_M, rd_en_M;
  logic [3:0] ccr_o, ccr_shadow_o;

  int n_tests = 0;
  int n_fail  = 0;

  // reference model state
  logic [7:0] m_res, m_sd, m_addr;
  logic [1:0] m_rd;
  logic       m_wr, m_wd, m_rden;
  logic [3:0] m_ccr, m_sh;

  always #5 clk = ~clk;

  ex_mem_stage #(.DATA_W(8), .ADDR_W(8)) dut (
    .clk(clk), .reset(reset), .stall_M(stall_M), .flush_M(flush_M),
    .alu_control_E(alu_control_E), .src_a_E(src_a_E), .src_b_E(src_b_E),
    .wr_en_regf_E(wr_en_regf_E), .wr_en_dmem_E(wr_en_dmem_E), .rd_en_E(rd_en_E),
    .f_save_E(f_save_E), .f_restore_E(f_restore_E), .rd_addr_E(rd_addr_E),
    .mem_addr_E(mem_addr_E), .alu_result_M(alu_result_M), .store_data_M(store_data_M),
    .mem_addr_M(mem_addr_M), .rd_addr_M(rd_addr_M), .wr_en_regf_M(wr_en_regf_M),
    .wr_en_dmem_M(wr_en_dmem_M), .rd_en_M(rd_en_M), .ccr_o(ccr_o),
    .ccr_shadow_o(ccr_shadow_o)
  );

  // ALU behaviour from the op table, in plain integer arithmetic
  function automatic logic [11:0] ref_alu(input int op, input int a, input int b,
                                          input logic [3:0] fin);
    int r, sa, sb, s;
    logic [3:0] f;
    bit zn;
    f = fin; zn = 0; r = 0; s = 0;
    sa = (a > 127) ? a - 256 : a;
    sb = (b > 127) ? b - 256 : b;
    case (op)
      1: r = b;
      2: begin r = a + b; f[2] = (r > 255); s = sa + sb; f[3] = (s > 127 || s < -128); zn = 1; end
      3: begin r = a - b; f[2] = (a < b);   s = sa - sb; f[3] = (s > 127 || s < -128); zn = 1; end
      4: begin r = a & b; zn = 1; end
      5: begin r = a | b; zn = 1; end
      6: begin r = 255 - a; zn = 1; end
      7: begin r = a + 1; f[2] = (r > 255); s = sa + 1; f[3] = (s > 127); zn = 1; end
      8: begin r = a - 1; f[2] = (a < 1);   s = sa - 1; f[3] = (s < -128); zn = 1; end
      9: f[2] = 1'b1;
      10: f[2] = 1'b0;
      11: begin r = a * 2 + int'(fin[2]); f[2] = (a >= 128); zn = 1; end
      12: begin r = int'(fin[2]) * 128 + a / 2; f[2] = (a % 2 == 1); zn = 1; end
      default: r = 0;
    endcase
    r = r & 255;
    if (zn) begin f[0] = (r == 0); f[1] = (r >= 128); end
    return {r[7:0], f};
  endfunction

  function automatic logic [36:0] exp_vec();
    return {m_res, m_sd, m_addr, m_rd, m_wr, m_wd, m_rden, m_ccr, m_sh};
  endfunction

  function automatic logic [36:0] dut_vec();
    return {alu_result_M, store_data_M, mem_addr_M, rd_addr_M, wr_en_regf_M,
            wr_en_dmem_M, rd_en_M, ccr_o, ccr_shadow_o};
  endfunction

  task automatic model_reset();
    m_res = 0; m_sd = 0; m_addr = 0; m_rd = 0; m_wr = 0; m_wd = 0; m_rden = 0;
    m_ccr = 0; m_sh = 0;
  endtask

  // One instruction: drive at negedge, advance model at posedge, settle 1ns
  task automatic step(input logic [5:0] op, input logic [7:0] a, input logic [7:0] b,
                      input bit st, input bit fl, input bit sv, input bit rs);
    logic [11:0] o;
    logic [3:0]  nccr, nsh;
    @(negedge clk);
    alu_control_E = op; src_a_E = a; src_b_E = b;
    stall_M = st; flush_M = fl; f_save_E = sv; f_restore_E = rs;
    wr_en_regf_E = 1'($urandom); wr_en_dmem_E = 1'($urandom); rd_en_E = 1'($urandom);
    rd_addr_E = 2'($urandom); mem_addr_E = 8'($urandom);
    @(posedge clk);
    if (fl) begin
      m_res = 0; m_sd = 0; m_addr = 0; m_rd = 0; m_wr = 0; m_wd = 0; m_rden = 0;
    end else if (!st) begin
      o = ref_alu(int'(op), int'(a), int'(b), m_ccr);
      m_res = o[11:4]; m_sd = b; m_addr = mem_addr_E; m_rd = rd_addr_E;
      m_wr = wr_en_regf_E; m_wd = wr_en_dmem_E; m_rden = rd_en_E;
      nccr = o[3:0]; nsh = m_sh;
`ifdef CCR_SHADOW_EN
      if (rs) nccr = m_sh;
      if (sv) nsh = m_ccr;
`endif
      m_ccr = nccr; m_sh = nsh;
    end
    #1;
  endtask

  task automatic test_reset();
    reset = 1'b0;
    step(6'd0, 8'h00, 8'h00, 0, 0, 0, 0);
    model_reset();
    n_tests++;
    if (dut_vec() !== 37'd0) begin
      n_fail++; $display("FAIL reset_init got=%h exp=0", dut_vec());
    end
    @(negedge clk); reset = 1'b1;
    for (int i = 0; i < 4; i++) step(6'(i + 1), 8'($urandom), 8'($urandom), 0, 0, 0, 0);
    // assert reset while an ADD sits in E
    @(negedge clk);
    alu_control_E = 6'd2; src_a_E = 8'h7F; src_b_E = 8'h01; wr_en_regf_E = 1;
    #2 reset = 1'b0;
    #1;
    model_reset();
    n_tests++;
    if (dut_vec() !== 37'd0) begin
      n_fail++; $display("FAIL reset_async got=%h exp=0", dut_vec());
    end
    @(posedge clk); #1;
    n_tests++;
    if (dut_vec() !== 37'd0) begin
      n_fail++; $display("FAIL reset_hold got=%h exp=0", dut_vec());
    end
    @(negedge clk); reset = 1'b1;
    step(6'd2, 8'h05, 8'h03, 0, 0, 0, 0);
    n_tests++;
    if (alu_result_M !== 8'h08 || ccr_o !== 4'b0000) begin
      n_fail++; $display("FAIL reset_first_add got=%h/%b exp=08/0000", alu_result_M, ccr_o);
    end
  endtask

  task automatic test_flags();
    step(6'd2, 8'h7F, 8'h01, 0, 0, 0, 0);
    n_tests++;
    if (alu_result_M !== 8'h80 || ccr_o !== 4'b1010) begin
      n_fail++; $display("FAIL add_ovf got=%h/%b exp=80/1010", alu_result_M, ccr_o);
    end
    step(6'd3, 8'h00, 8'h01, 0, 0, 0, 0);
    n_tests++;
    if (alu_result_M !== 8'hFF || ccr_o !== 4'b0110) begin
      n_fail++; $display("FAIL sub_borrow got=%h/%b exp=FF/0110", alu_result_M, ccr_o);
    end
    step(6'd4, 8'hF0, 8'h0F, 0, 0, 0, 0);
    n_tests++;
    if (alu_result_M !== 8'h00 || ccr_o !== 4'b0101) begin
      n_fail++; $display("FAIL and_zero got=%h/%b exp=00/0101", alu_result_M, ccr_o);
    end
    n_tests++;
    if (dut_vec() !== exp_vec()) begin
      n_fail++; $display("FAIL flags_model got=%h exp=%h", dut_vec(), exp_vec());
    end
  endtask

  task automatic test_stall_flush();
    logic [36:0] snap;
    step(6'd2, 8'h12, 8'h34, 0, 0, 0, 0);
    snap = dut_vec();
    for (int i = 0; i < 2; i++) begin
      step(6'd3, 8'($urandom), 8'($urandom), 1, 0, 0, 0);
      n_tests++;
      if (dut_vec() !== snap || dut_vec() !== exp_vec()) begin
        n_fail++; $display("FAIL stall_hold%0d got=%h exp=%h", i, dut_vec(), snap);
      end
    end
    step(6'd2, 8'hFF, 8'h01, 0, 1, 0, 0);
    n_tests++;
    if (dut_vec() !== {29'd0, snap[7:0]}) begin
      n_fail++; $display("FAIL flush_nop got=%h exp=%h", dut_vec(), {29'd0, snap[7:0]});
    end
    step(6'd1, 8'h00, 8'h5A, 0, 0, 0, 0);
    step(6'd7, 8'hFF, 8'h11, 1, 1, 0, 0);
    n_tests++;
    if (dut_vec() !== exp_vec() || alu_result_M !== 8'h00 || store_data_M !== 8'h00) begin
      n_fail++; $display("FAIL flush_stall got=%h exp=%h", dut_vec(), exp_vec());
    end
  endtask

  task automatic test_shadow();
    logic [3:0] e_ccr [5];
    logic [3:0] e_sh  [5];
`ifdef CCR_SHADOW_EN
    e_ccr = '{4'b0100, 4'b0000, 4'b0100, 4'b0001, 4'b0100};
    e_sh  = '{4'b0100, 4'b0100, 4'b0100, 4'b0100, 4'b0001};
`else
    e_ccr = '{4'b0100, 4'b0000, 4'b0000, 4'b0001, 4'b0001};
    e_sh  = '{4'b0000, 4'b0000, 4'b0000, 4'b0000, 4'b0000};
`endif
    // establish CCR = 0100 with shadow left at whatever earlier steps gave
    step(6'd2, 8'h00, 8'h00, 0, 0, 0, 0);
    step(6'd9, 8'h00, 8'h00, 0, 0, 0, 0);
    step(6'd4, 8'h01, 8'h01, 0, 0, 0, 0);
    for (int i = 0; i < 5; i++) begin
      case (i)
        0: step(6'd0, 8'h00, 8'h00, 0, 0, 1, 0);
        1: step(6'd10, 8'h00, 8'h00, 0, 0, 0, 0);
        2: step(6'd0, 8'h00, 8'h00, 0, 0, 0, 1);
        3: step(6'd2, 8'h00, 8'h00, 0, 0, 0, 0);
        default: step(6'd0, 8'h00, 8'h00, 0, 0, 1, 1);
      endcase
      n_tests++;
      if (ccr_o !== e_ccr[i] || ccr_shadow_o !== e_sh[i]) begin
        n_fail++;
        $display("FAIL shadow_step%0d got=%b/%b exp=%b/%b", i, ccr_o, ccr_shadow_o, e_ccr[i], e_sh[i]);
      end
    end
  endtask

  task automatic test_rotates();
    logic [3:0] held;
    step(6'd9, 8'h00, 8'h00, 0, 0, 0, 0);
    step(6'd11, 8'h80, 8'h00, 0, 0, 0, 0);
    n_tests++;
    if (alu_result_M !== 8'h01 || ccr_o[2] !== 1'b1 || ccr_o[1:0] !== 2'b00) begin
      n_fail++; $display("FAIL rlc got=%h/%b exp=01/C=1", alu_result_M, ccr_o);
    end
    step(6'd12, 8'h01, 8'h00, 0, 0, 0, 0);
    n_tests++;
    if (alu_result_M !== 8'h80 || ccr_o[2:0] !== 3'b110) begin
      n_fail++; $display("FAIL rrc got=%h/%b exp=80/C=1,N=1", alu_result_M, ccr_o);
    end
    held = ccr_o;
    step(6'd40, 8'h5A, 8'hA5, 0, 0, 0, 0);
    n_tests++;
    if (alu_result_M !== 8'h00 || ccr_o !== held) begin
      n_fail++; $display("FAIL unused_op got=%h/%b exp=00/%b", alu_result_M, ccr_o, held);
    end
  endtask

  task automatic test_random();
    logic [5:0] op;
    for (int i = 0; i < 400; i++) begin
      op = ($urandom_range(0, 7) == 0) ? 6'($urandom_range(13, 63)) : 6'($urandom_range(0, 12));
      step(op, 8'($urandom), 8'($urandom), ($urandom_range(0, 5) == 0),
           ($urandom_range(0, 7) == 0), ($urandom_range(0, 4) == 0), ($urandom_range(0, 4) == 0));
      n_tests++;
      if (dut_vec() !== exp_vec()) begin
        n_fail++; $display("FAIL random%0d op=%0d got=%h exp=%h", i, op, dut_vec(), exp_vec());
      end
    end
  endtask

  initial begin
    reset = 1'b0; stall_M = 0; flush_M = 0; alu_control_E = 0; src_a_E = 0; src_b_E = 0;
    wr_en_regf_E = 0; wr_en_dmem_E = 0; rd_en_E = 0; f_save_E = 0; f_restore_E = 0;
    rd_addr_E = 0; mem_addr_E = 0;
    model_reset();
    test_reset();
    test_flags();
    test_stall_flush();
    test_shadow();
    test_rotates();
    test_random();
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
